// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, keeps one imem request in flight and buffers the result for decode.
// Redirects from execute win over everything and squash any in-flight or buffered fetch.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_DROP,
    S_HOLD
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [63:0] r_pc;
  logic [63:0] w_pc_nxt;
  logic        r_if_valid;
  logic        w_if_valid_nxt;
  logic [31:0] r_if_instr;
  logic [31:0] w_if_instr_nxt;
  logic [63:0] r_if_pc;
  logic [63:0] w_if_pc_nxt;
  logic        r_fault;
  logic        w_misaligned;
  logic [63:0] w_redir_pc;

  assign w_redir_pc   = {redirect_pc[63:2], 2'b00};
  assign w_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_instr <= NOP;
      r_if_pc    <= RESET_PC;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_if_instr <= w_if_instr_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_fault    <= w_misaligned;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_if_valid_nxt = r_if_valid;
    w_if_instr_nxt = r_if_instr;
    w_if_pc_nxt    = r_if_pc;
    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_REQ;
        if (redirect_valid) w_pc_nxt = w_redir_pc;
      end
      S_REQ: begin
        // A redirect that coincides with acceptance leaves a stale request behind
        if (redirect_valid) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = imem_req_ready ? S_DROP : S_REQ;
        end else if (imem_req_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = imem_resp_valid ? S_REQ : S_DROP;
        end else if (imem_resp_valid) begin
          w_if_instr_nxt = imem_resp_data;
          w_if_pc_nxt    = r_pc;
          w_if_valid_nxt = 1'b1;
          w_state_nxt    = S_HOLD;
        end
      end
      S_DROP: begin
        if (redirect_valid) w_pc_nxt = w_redir_pc;
        if (imem_resp_valid) w_state_nxt = S_REQ;
      end
      S_HOLD: begin
        if (redirect_valid) begin
          w_pc_nxt       = w_redir_pc;
          w_if_valid_nxt = 1'b0;
          w_state_nxt    = S_REQ;
        end else if (if_ready) begin
          w_pc_nxt       = r_pc + 64'd4;
          w_if_valid_nxt = 1'b0;
          w_state_nxt    = S_REQ;
        end
      end
      default: begin
        w_state_nxt    = S_BOOT;
        w_if_valid_nxt = 1'b0;
      end
    endcase
  end

  assign imem_req_valid = (r_state == S_REQ);
  assign imem_req_addr  = r_pc;
  assign if_valid       = r_if_valid;
  assign if_instr       = r_if_instr;
  assign if_pc          = r_if_pc;
  assign fetch_fault    = r_fault;

endmodule

// File: tb/tb_instruction_fetch.sv
// Random bench for instruction_fetch: a memory responder and random decode/redirect driver,
// checked against a program-order model (next PC is previous+4 unless execute redirected).
module tb_instruction_fetch;

  localparam logic [63:0] RST_PC = 64'h1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        fetch_fault;

  int checks   = 0;
  int failures = 0;
  int transfers = 0;

  instruction_fetch #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0050_0093;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_if_valid", 64'(if_valid), 64'd0);
    chk("rst_if_instr", 64'(if_instr), 64'h13);
    chk("rst_if_pc", if_pc, RST_PC);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_req_addr", imem_req_addr, RST_PC);
    chk("rst_fault", 64'(fetch_fault), 64'd0);
  endtask

  // Driver: memory responder plus random decode-ready and redirect stimulus
  logic        mem_busy;
  logic [63:0] mem_addr;
  int          mem_lat;

  initial begin
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if_ready        = 1'b0;
    mem_busy        = 1'b0;
    mem_addr        = '0;
    mem_lat         = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_busy        = 1'b0;
        redirect_valid  = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        if_ready        = 1'b0;
      end else begin
        if (mem_busy) begin
          if (mem_lat == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mem_addr);
            mem_busy        = 1'b0;
          end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
            mem_lat--;
          end
        end else begin
          // Spurious responses while nothing is outstanding must be ignored
          imem_resp_valid = ($urandom_range(0, 7) == 0);
          imem_resp_data  = $urandom;
        end
        imem_req_ready = ($urandom_range(0, 2) != 0);
        if_ready       = ($urandom_range(0, 1) == 1);
        redirect_valid = ($urandom_range(0, 15) == 0);
        case ($urandom_range(0, 4))
          0:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
          1:       redirect_pc = 64'h2000;
          2:       redirect_pc = 64'h2002;
          3:       redirect_pc = 64'h3000;
          default: redirect_pc = {$urandom, $urandom};
        endcase
        if (imem_req_valid && imem_req_ready) begin
          mem_busy = 1'b1;
          mem_addr = imem_req_addr;
          mem_lat  = $urandom_range(0, 2);
        end
      end
    end
  end

  // Monitor / scoreboard: exp_q front is the PC decode must see next
  logic [63:0] exp_q[$];
  logic        fault_exp;
  logic        hold_exp;
  logic        req_hold_exp;
  logic        nvld_exp;
  int          stall;

  initial begin
    fault_exp    = 1'b0;
    hold_exp     = 1'b0;
    req_hold_exp = 1'b0;
    nvld_exp     = 1'b0;
    stall        = 0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        exp_q.delete();
        exp_q.push_back(RST_PC);
        fault_exp    = 1'b0;
        hold_exp     = 1'b0;
        req_hold_exp = 1'b0;
        nvld_exp     = 1'b0;
        stall        = 0;
      end else begin
        chk("fetch_fault", 64'(fetch_fault), 64'(fault_exp));
        if (hold_exp) chk("if_valid_held", 64'(if_valid), 64'd1);
        if (nvld_exp) chk("if_valid_cleared", 64'(if_valid), 64'd0);
        if (req_hold_exp) chk("req_valid_held", 64'(imem_req_valid), 64'd1);
        if (imem_req_valid) chk("req_addr", imem_req_addr, exp_q[0]);
        if (if_valid) begin
          chk("no_req_in_hold", 64'(imem_req_valid), 64'd0);
          chk("if_pc", if_pc, exp_q[0]);
          chk("if_instr", 64'(if_instr), 64'(mem_word(exp_q[0])));
        end
        fault_exp    = redirect_valid && (redirect_pc[1:0] != 2'b00);
        hold_exp     = if_valid && !if_ready && !redirect_valid;
        req_hold_exp = imem_req_valid && !imem_req_ready && !redirect_valid;
        nvld_exp     = redirect_valid || (if_valid && if_ready);
        if (if_valid && if_ready) begin
          transfers++;
          stall = 0;
        end else begin
          stall++;
        end
        if (redirect_valid) begin
          exp_q.delete();
          exp_q.push_back({redirect_pc[63:2], 2'b00});
        end else if (if_valid && if_ready) begin
          logic [63:0] p;
          p = exp_q.pop_front();
          exp_q.push_back(p + 64'd4);
        end
        if (stall > 300) begin
          chk("progress_watchdog", 64'(stall), 64'd300);
          stall = 0;
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("boot_no_req", 64'(imem_req_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("first_req", 64'(imem_req_valid), 64'd1);
    repeat (1500) @(negedge clk);

    // Asynchronous reset in the middle of a cycle
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("boot_no_req2", 64'(imem_req_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("first_req2", 64'(imem_req_valid), 64'd1);
    repeat (1500) @(negedge clk);

    checks++;
    if (transfers < 50) begin
      failures++;
      $display("FAIL transfers actual=%0d required>=50", transfers);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
